// File: rtl/store_buffer_pkg.sv
// Shared store-path definitions: access-size encodings (common with the load
// extender), the store-address exception code and byte-lane widths.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    be_default = 2'b00,
    be_byte    = 2'b01,
    be_half    = 2'b10,
    be_word    = 2'b11
  } beop_e;

  localparam int          BE_W     = 4;
  localparam int          LANE_W   = 8;
  localparam int          DATA_W   = BE_W * LANE_W;
  localparam logic [4:0]  EXC_ADES = 5'd5;

  function automatic logic is_misaligned(input beop_e op, input logic [1:0] a);
    logic mis;
    case (op)
      be_half: mis = a[0];
      be_word: mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline/memory-facing signal bundle of the store buffer.
interface store_buffer_if #(parameter int ADDR_W = 32);
  import store_buffer_pkg::*;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  beop_e             st_beop;
  logic              st_misalign;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hazard;
  logic              empty;

  modport master (
    output st_valid, st_addr, st_data, st_beop, mem_ack, ld_valid, ld_addr,
    input  st_ready, st_misalign, mem_req, mem_addr, mem_be, mem_wdata, ld_hazard, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_beop, mem_ack, ld_valid, ld_addr,
    output st_ready, st_misalign, mem_req, mem_addr, mem_be, mem_wdata, ld_hazard, empty
  );

endinterface

// File: rtl/store_buffer_lane_align.sv
// Places raw register data onto byte lanes and derives byte enables and the
// misalignment condition for one store.
module store_buffer_lane_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] data_i,
  input  beop_e             beop_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              misalign_o
);

  // Lane replication and enable pattern per access size
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0000_0000;
    misalign_o = is_misaligned(beop_i, addr_lo_i);
    case (beop_i)
      be_byte: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{data_i[7:0]}};
      end
      be_half: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      be_word: begin
        be_o    = 4'b1111;
        wdata_o = data_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Small store FIFO between MEM and data memory: aligns stores, drains them over
// req/ack and flags loads that hit a pending store word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  store_buffer_if.slave sb
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]   waddr_q [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [BE_W-1:0]   al_be_s;
  logic [DATA_W-1:0] al_wdata_s;
  logic              al_mis_s;
  logic              empty_s, full_s, push_s, pop_s, hit_s;

  store_buffer_lane_align u_align (
    .addr_lo_i (sb.st_addr[1:0]),
    .data_i    (sb.st_data),
    .beop_i    (sb.st_beop),
    .be_o      (al_be_s),
    .wdata_o   (al_wdata_s),
    .misalign_o(al_mis_s)
  );

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == CNT_W'(DEPTH));
  // Acceptance depends on count alone, so a same-cycle pop never frees a full slot
  assign push_s  = sb.st_valid && !full_s && !al_mis_s && (sb.st_beop != be_default);
  assign pop_s   = !empty_s && sb.mem_ack;

  // Pointer, count and occupancy next state
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = (push_s && wr_ptr_q == PTR_W'(i)) ? 1'b1 :
                   (pop_s  && rd_ptr_q == PTR_W'(i)) ? 1'b0 : valid_q[i];
    end
  end

  // FIFO state and entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        be_q[i]    <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (push_s) begin
        waddr_q[wr_ptr_q] <= sb.st_addr[ADDR_W-1:2];
        be_q[wr_ptr_q]    <= al_be_s;
        wdata_q[wr_ptr_q] <= al_wdata_s;
      end
    end
  end

  // Word-granular hazard compare; the incoming store is deliberately excluded
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (waddr_q[i] == sb.ld_addr[ADDR_W-1:2])) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign sb.st_ready   = !full_s;
  assign sb.st_misalign = sb.st_valid && al_mis_s;
  assign sb.empty      = empty_s;
  assign sb.mem_req    = !empty_s;
  assign sb.mem_addr   = empty_s ? '0 : {waddr_q[rd_ptr_q], 2'b00};
  assign sb.mem_be     = empty_s ? 4'b0000 : be_q[rd_ptr_q];
  assign sb.mem_wdata  = empty_s ? 32'h0000_0000 : wdata_q[rd_ptr_q];
  assign sb.ld_hazard  = sb.ld_valid && hit_s;

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.ADDR_W(ADDR_W)) sb();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: what a store request turns into, from the access-size rules
  task automatic model_store(input beop_e op, input logic [31:0] addr, input logic [31:0] data,
                             output bit ok, output bit mis, output exp_t e);
    int a;
    a      = int'(addr % 4);
    e.addr = addr & 32'hFFFF_FFFC;
    e.be   = 4'h0;
    e.data = 32'h0;
    ok     = 1'b0;
    mis    = 1'b0;
    case (op)
      be_byte: begin
        e.be   = 4'(1 << a);
        e.data = {24'h0, data[7:0]} * 32'h0101_0101;
        ok     = 1'b1;
      end
      be_half: begin
        mis    = (a % 2) == 1;
        e.be   = (a >= 2) ? 4'hC : 4'h3;
        e.data = {16'h0, data[15:0]} * 32'h0001_0001;
        ok     = !mis;
      end
      be_word: begin
        mis    = (a != 0);
        e.be   = 4'hF;
        e.data = data;
        ok     = !mis;
      end
      default: ok = 1'b0;
    endcase
  endtask

  // Monitor: compare outputs with the model, then advance the model for the coming edge
  always @(negedge clk) begin
    exp_t e;
    bit   ok, mis, hz, full;
    if (!rst_n) exp_q.delete();
    check("empty",    32'(sb.empty),    32'(exp_q.size() == 0));
    check("st_ready", 32'(sb.st_ready), 32'(exp_q.size() != DEPTH));
    check("mem_req",  32'(sb.mem_req),  32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("mem_addr",  sb.mem_addr,      exp_q[0].addr);
      check("mem_be",    32'(sb.mem_be),   32'(exp_q[0].be));
      check("mem_wdata", sb.mem_wdata,     exp_q[0].data);
    end else begin
      check("mem_addr_idle",  sb.mem_addr,    32'h0);
      check("mem_be_idle",    32'(sb.mem_be), 32'h0);
      check("mem_wdata_idle", sb.mem_wdata,   32'h0);
    end
    model_store(sb.st_beop, sb.st_addr, sb.st_data, ok, mis, e);
    check("st_misalign", 32'(sb.st_misalign), 32'(sb.st_valid && mis));
    hz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].addr[31:2] == sb.ld_addr[31:2]) hz = 1'b1;
    check("ld_hazard", 32'(sb.ld_hazard), 32'(sb.ld_valid && hz));
    if (rst_n) begin
      full = (exp_q.size() == DEPTH);
      if (exp_q.size() != 0 && sb.mem_ack) void'(exp_q.pop_front());
      if (sb.st_valid && !full && ok) exp_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input beop_e op);
    sb.st_valid = 1'b1;
    sb.st_addr  = a;
    sb.st_data  = d;
    sb.st_beop  = op;
  endtask

  initial begin
    sb.st_valid = 1'b0;
    sb.st_addr  = 32'h0;
    sb.st_data  = 32'h0;
    sb.st_beop  = be_default;
    sb.mem_ack  = 1'b0;
    sb.ld_valid = 1'b0;
    sb.ld_addr  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_empty",    32'(sb.empty),    32'h1);
    check("reset_st_ready", 32'(sb.st_ready), 32'h1);
    check("reset_mem_req",  32'(sb.mem_req),  32'h0);
    rst_n = 1'b1;

    // Byte store to lane 3, then hazard probes on the pending word
    store(32'h0000_1003, 32'h0000_00A5, be_byte);
    sb.mem_ack = 1'b1;
    step();
    sb.st_valid = 1'b0;
    check("sb_mem_req",   32'(sb.mem_req),   32'h1);
    check("sb_mem_addr",  sb.mem_addr,       32'h0000_1000);
    check("sb_mem_be",    32'(sb.mem_be),    32'h8);
    check("sb_mem_wdata", sb.mem_wdata,      32'hA5A5_A5A5);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h0000_1002;
    #1 check("hazard_same_word", 32'(sb.ld_hazard), 32'h1);
    sb.ld_addr  = 32'h0000_1004;
    #1 check("hazard_next_word", 32'(sb.ld_hazard), 32'h0);
    sb.ld_valid = 1'b0;
    sb.ld_addr  = 32'h0000_1000;
    #1 check("hazard_no_load", 32'(sb.ld_hazard), 32'h0);
    step();
    check("sb_drained", 32'(sb.empty), 32'h1);

    // Misaligned half/word, then an aligned upper half
    store(32'h0000_2001, 32'h0000_1234, be_half);
    #1 check("sh_misalign", 32'(sb.st_misalign), 32'h1);
    step();
    check("sh_mis_no_req", 32'(sb.mem_req), 32'h0);
    store(32'h0000_2002, 32'h0000_1234, be_word);
    #1 check("sw_misalign", 32'(sb.st_misalign), 32'h1);
    store(32'h0000_2002, 32'h0000_1234, be_half);
    #1 check("sh_aligned", 32'(sb.st_misalign), 32'h0);
    step();
    sb.st_valid = 1'b0;
    check("sh_mem_addr",  sb.mem_addr,    32'h0000_2000);
    check("sh_mem_be",    32'(sb.mem_be), 32'hC);
    check("sh_mem_wdata", sb.mem_wdata,   32'h1234_1234);
    step();

    // Fill with ack low, hold a third store, then release ack
    sb.mem_ack = 1'b0;
    store(32'h0000_0010, 32'h1111_1111, be_word);
    step();
    store(32'h0000_0014, 32'h2222_2222, be_word);
    step();
    check("fill_full", 32'(sb.st_ready), 32'h0);
    store(32'h0000_0018, 32'h3333_3333, be_word);
    step();
    check("fill_held_head", sb.mem_addr, 32'h0000_0010);
    check("fill_still_full", 32'(sb.st_ready), 32'h0);
    sb.mem_ack = 1'b1;
    step();
    check("order_second", sb.mem_addr, 32'h0000_0014);
    check("order_ready",  32'(sb.st_ready), 32'h1);
    step();
    sb.st_valid = 1'b0;
    check("pushpop_third", sb.mem_addr, 32'h0000_0018);
    check("pushpop_count", 32'(sb.empty), 32'h0);
    step();
    check("fill_drained", 32'(sb.empty), 32'h1);

    // Asynchronous reset with two pending entries
    sb.mem_ack = 1'b0;
    store(32'h0000_0040, 32'h4444_4444, be_word);
    step();
    store(32'h0000_0044, 32'h5555_5555, be_word);
    step();
    sb.st_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_req",  32'(sb.mem_req),  32'h0);
    check("rst_empty",    32'(sb.empty),    32'h1);
    check("rst_st_ready", 32'(sb.st_ready), 32'h1);
    check("rst_mem_be",   32'(sb.mem_be),   32'h0);
    step();
    rst_n = 1'b1;
    sb.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_stale", 32'(sb.mem_req), 32'h0);
    end

    // Random traffic on a few words so hazards and collisions are frequent
    for (int i = 0; i < 400; i++) begin
      sb.st_valid = ($urandom % 4) != 0;
      sb.st_addr  = 32'h100 + ($urandom % 4) * 4 + ($urandom % 4);
      sb.st_data  = $urandom;
      sb.st_beop  = beop_e'(2'($urandom_range(3, 0)));
      sb.mem_ack  = ($urandom % 3) != 0;
      sb.ld_valid = ($urandom % 2) != 0;
      sb.ld_addr  = 32'h100 + ($urandom % 16);
      step();
    end
    sb.st_valid = 1'b0;
    sb.ld_valid = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart to the W-stage load extender.
- Accepts store requests from the MEM stage as byte address, raw register data and BEOp.
- Aligns data onto byte lanes, generates 4-bit byte enables and queues each store in a small FIFO.
- Drains the FIFO to data memory over a req/ack handshake and flags loads that hit a pending store's word (load hazard), so the pipeline can stall.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, >= 2).
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- st_valid  input  1  store request present.
- st_ready  output  1  buffer can accept a store (= not full).
- st_addr  input  ADDR_W  store byte address.
- st_data  input  32  unaligned store data from rt.
- st_beop  input  2  access size; uses shared constants be_byte, be_half, be_word, be_default.
- st_misalign  output  1  store address exception, combinational.
- mem_req  output  1  head entry valid, write requested.
- mem_ack  input  1  memory accepted the head write this cycle.
- mem_addr  output  ADDR_W  word address of head entry, with bits [1:0] = 0.
- mem_be  output  4  byte enables of head entry.
- mem_wdata  output  32  lane-aligned data of head entry.
- ld_valid  input  1  a load is in MEM this cycle.
- ld_addr  input  ADDR_W  load byte address.
- ld_hazard  output  1  load word matches a buffered store.
- empty  output  1  no buffered entries.

Behaviour:
- **Reset** (rst_n low, async):
  - Pointers and count clear; all entries are discarded, including any store mid-handshake.
  - mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, ld_hazard=0, empty=1, st_ready=1.
- **Lane alignment**, with a = st_addr[1:0]:
  - be_byte: be = 4'b0001 << a; wdata = {4{st_data[7:0]}}.
  - be_half: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - be_word: be = 4'b1111; wdata = st_data.
  - be_default: request is consumed, nothing is enqueued, no exception.
- **Misalignment**:
  - Condition: (be_half and a[0]=1) or (be_word and a != 0).
  - st_misalign = st_valid and that condition.
  - The store is not enqueued; st_ready is unaffected.
- **Enqueue**:
  - Fires when st_valid & st_ready & aligned & beop != be_default.
  - The entry {st_addr[ADDR_W-1:2], be, wdata} is written at the write pointer on the rising edge.
  - It is visible on mem_* no earlier than the next cycle (1-cycle latency).
- **Drain**:
  - mem_req = !empty; mem_* come from the head entry and are forced to 0 when empty.
  - Pop occurs on mem_req & mem_ack. mem_ack while empty is ignored.
  - mem_* stay stable while mem_req=1 and mem_ack=0.
- **Full and simultaneous events**:
  - st_ready = (count != DEPTH), decided by count alone; a pop in the same cycle does not admit a push while full.
  - Push and pop together when not full and not empty: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- **Order**: entries drain strictly in FIFO order.
- **Load hazard**:
  - ld_hazard = ld_valid and any valid entry has addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]; combinational.
  - Byte enables are not considered.
  - A store being enqueued the same cycle is not compared.
  - An entry popping the same cycle still counts.
- **empty**: count == 0, combinational from registered state.

Decomposition:
- **Shared header**:
  - be_byte, be_half, be_word, be_default encodings (already used by the load extender).
  - Store-address-exception code.
  - Byte-enable widths.
- **Sub-module store_lane_align**: combinational; (addr[1:0], data, beop) -> (be, wdata, misalign).
- **store_buffer**: holds the FIFO, the count and pointers, and the hazard comparators.

Test Plan:
- **Alignment**: sb addr=0x1003 data=0x000000A5, ack held 1 -> next cycle mem_req=1, mem_addr=0x1000, mem_be=0001<<3=1000, mem_wdata=0xA5A5A5A5; following cycle empty=1.
- **Misalignment**: sh addr=0x2001 -> st_misalign=1 same cycle, mem_req stays 0. sw addr=0x2002 -> st_misalign=1. sh addr=0x2002 data=0x1234 -> mem_be=1100, mem_wdata=0x12341234.
- **Fill and order**: mem_ack=0; issue 3 sw (0x10, 0x14, 0x18) -> st_ready=0 after 2; third held. Release ack -> writes appear in order 0x10, 0x14, then third accepted and written.
- **Push/pop same cycle**: count=1 with ack=1 and a new store -> count stays 1, order preserved.
- **Load hazard**: entry at 0x1000 pending; ld addr=0x1002 -> ld_hazard=1; ld addr=0x1004 -> 0; ld_valid=0 -> 0.
- **Reset mid-operation**: 2 entries, ack=0, pulse rst_n low mid-cycle -> mem_req=0 immediately, empty=1, st_ready=1; no stale writes after release.
